// File: rtl/fifo_wr_pkg.sv
// fifo_wr_pkg: shared state type, header defaults and widths for the FIFO write controller
package fifo_wr_pkg;
  localparam int BIT_W = 3;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] HDR_A_DEF = 8'hA5;
  localparam logic [BYTE_W-1:0] HDR_B_DEF = 8'hC3;
  typedef enum logic [1:0] {HUNT, PAYLOAD, DONE} state_t;
endpackage

// File: rtl/byte_deser.sv
// byte_deser: MSB-first serial-to-byte deserializer; in clk/reset_n/serial_data/data_ena, out byte_vld/byte_val (combinational, valid on the 8th bit)
module byte_deser
  import fifo_wr_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic              byte_vld,
  output logic [BYTE_W-1:0] byte_val
);
  logic [BYTE_W-2:0] r_shift;
  logic [BIT_W-1:0]  r_bit_cnt;
  assign byte_vld = data_ena && (&r_bit_cnt);
  assign byte_val = {r_shift, serial_data};
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (data_ena) begin
      r_shift   <= byte_val[BYTE_W-2:0];
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end else
      r_bit_cnt <= '0;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: header-hunting FIFO writer; in clk/reset_n/serial_data/data_ena/full_flag, out wr_fifo/fifo_data/pkt_done/overflow
module fifo_wr_ctrl
  import fifo_wr_pkg::*;
#(
  parameter int                BYTES_PER_PKT = 4,
  parameter logic [BYTE_W-1:0] HDR_A         = HDR_A_DEF,
  parameter logic [BYTE_W-1:0] HDR_B         = HDR_B_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              serial_data,
  input  logic              data_ena,
  input  logic              full_flag,
  output logic              wr_fifo,
  output logic [BYTE_W-1:0] fifo_data,
  output logic              pkt_done,
  output logic              overflow
);
  localparam logic [3:0] LAST = 4'(BYTES_PER_PKT - 1);
  state_t            r_state;
  logic [3:0]        r_byte_cnt;
  logic              w_vld;
  logic [BYTE_W-1:0] w_byte;
  logic              w_hdr;
  logic              w_pay;
  logic              w_last;
  byte_deser u_deser (
    .clk        (clk),
    .reset_n    (reset_n),
    .serial_data(serial_data),
    .data_ena   (data_ena),
    .byte_vld   (w_vld),
    .byte_val   (w_byte)
  );
  assign w_hdr  = w_vld && (w_byte == HDR_A || w_byte == HDR_B);
  assign w_pay  = w_vld && r_state == PAYLOAD;
  assign w_last = r_byte_cnt == LAST;
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_state    <= HUNT;
      r_byte_cnt <= '0;
      wr_fifo    <= 1'b0;
      fifo_data  <= '0;
      pkt_done   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_state    <= r_state == PAYLOAD ? (w_vld && w_last ? DONE : PAYLOAD) : (w_hdr ? PAYLOAD : HUNT);
      r_byte_cnt <= r_state == PAYLOAD ? r_byte_cnt + 4'(w_vld) : 4'd0;
      wr_fifo    <= w_pay && !full_flag;
      fifo_data  <= w_pay && !full_flag ? w_byte : fifo_data;
      pkt_done   <= w_pay && w_last;
      overflow   <= overflow | (w_pay && full_flag);
    end
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_data = 1'b0;
  logic       data_ena = 1'b0;
  logic       full_flag = 1'b0;
  logic       wr_fifo;
  logic [7:0] fifo_data;
  logic       pkt_done;
  logic       overflow;
  logic [10:0] obs;
  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  logic prev_wr = 1'b0;
  logic b2b = 1'b0;
  fifo_wr_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .serial_data(serial_data),
    .data_ena   (data_ena),
    .full_flag  (full_flag),
    .wr_fifo    (wr_fifo),
    .fifo_data  (fifo_data),
    .pkt_done   (pkt_done),
    .overflow   (overflow)
  );
  always #5 clk = ~clk;
  assign obs = {wr_fifo, fifo_data, pkt_done, overflow};
  always @(negedge clk) begin
    if (wr_fifo) wr_cnt++;
    if (wr_fifo && prev_wr) b2b = 1'b1;
    prev_wr = wr_fifo;
  end
  task automatic send_byte(input logic [7:0] b, input logic full);
    full_flag = full;
    for (int i = 7; i >= 0; i--) begin
      serial_data = b[i];
      data_ena = 1'b1;
      @(posedge clk);
      #1;
    end
    full_flag = 1'b0;
  endtask
  task automatic idle(input int n);
    data_ena = 1'b0;
    serial_data = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset_init;
    reset_n = 1'b0;
    idle(3);
    vectors++;
    if (obs !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_init obs got %h exp %h", obs, 11'h000);
    end
    reset_n = 1'b1;
    idle(1);
  endtask
  task automatic test_header_a;
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int n0 = wr_cnt;
    send_byte(8'hA5, 1'b0);
    vectors++;
    if (wr_fifo !== 1'b0) begin
      miscompares++;
      $display("FAIL hdrA header_wr got %b exp 0", wr_fifo);
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i], 1'b0);
      vectors++;
      if (obs !== {1'b1, d[i], i == 3, 1'b0}) begin
        miscompares++;
        $display("FAIL hdrA byte%0d {wr,data,done,ovf} got %h exp %h", i, obs, {1'b1, d[i], i == 3, 1'b0});
      end
    end
    idle(1);
    vectors++;
    if (obs !== {1'b0, 8'h44, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL hdrA after {wr,data,done,ovf} got %h exp %h", obs, {1'b0, 8'h44, 1'b0, 1'b0});
    end
    vectors++;
    if (wr_cnt - n0 !== 4) begin
      miscompares++;
      $display("FAIL hdrA write_count got %0d exp 4", wr_cnt - n0);
    end
  endtask
  task automatic test_non_header;
    logic [7:0] d [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int n0 = wr_cnt;
    send_byte(8'h5A, 1'b0);
    vectors++;
    if (wr_fifo !== 1'b0) begin
      miscompares++;
      $display("FAIL nonhdr 5A_wr got %b exp 0", wr_fifo);
    end
    send_byte(8'h3C, 1'b0);
    vectors++;
    if (wr_fifo !== 1'b0) begin
      miscompares++;
      $display("FAIL nonhdr 3C_wr got %b exp 0", wr_fifo);
    end
    send_byte(8'hC3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i], 1'b0);
      vectors++;
      if (obs !== {1'b1, d[i], i == 3, 1'b0}) begin
        miscompares++;
        $display("FAIL nonhdr byte%0d {wr,data,done,ovf} got %h exp %h", i, obs, {1'b1, d[i], i == 3, 1'b0});
      end
    end
    idle(1);
    vectors++;
    if (wr_cnt - n0 !== 4) begin
      miscompares++;
      $display("FAIL nonhdr write_count got %0d exp 4", wr_cnt - n0);
    end
  endtask
  task automatic test_no_resync;
    logic [7:0] d [4] = '{8'hA5, 8'hC3, 8'hFF, 8'h00};
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i], 1'b0);
      vectors++;
      if (obs !== {1'b1, d[i], i == 3, 1'b0}) begin
        miscompares++;
        $display("FAIL noresync byte%0d {wr,data,done,ovf} got %h exp %h", i, obs, {1'b1, d[i], i == 3, 1'b0});
      end
    end
    idle(1);
    send_byte(8'h11, 1'b0);
    vectors++;
    if ({wr_fifo, pkt_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL noresync hunt_after {wr,done} got %b exp 00", {wr_fifo, pkt_done});
    end
    idle(1);
  endtask
  task automatic test_partial;
    logic [7:0] d [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    serial_data = 1'b1;
    data_ena = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    idle(2);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i], 1'b0);
      vectors++;
      if (obs !== {1'b1, d[i], i == 3, 1'b0}) begin
        miscompares++;
        $display("FAIL partial byte%0d {wr,data,done,ovf} got %h exp %h", i, obs, {1'b1, d[i], i == 3, 1'b0});
      end
    end
    idle(1);
  endtask
  task automatic test_back_to_back;
    logic [7:0] d [4] = '{8'h77, 8'h78, 8'h79, 8'h7A};
    send_byte(8'hA5, 1'b0);
    vectors++;
    if (wr_fifo !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b header_wr got %b exp 0", wr_fifo);
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i], 1'b0);
      vectors++;
      if (obs !== {1'b1, d[i], i == 3, 1'b0}) begin
        miscompares++;
        $display("FAIL b2b byte%0d {wr,data,done,ovf} got %h exp %h", i, obs, {1'b1, d[i], i == 3, 1'b0});
      end
    end
    idle(1);
  endtask
  task automatic test_overflow;
    logic [7:0] d [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] last = 8'h7A;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i], i == 1);
      if (i != 1) last = d[i];
      vectors++;
      if (obs !== {i != 1, last, i == 3, i >= 1}) begin
        miscompares++;
        $display("FAIL overflow byte%0d {wr,data,done,ovf} got %h exp %h", i, obs, {i != 1, last, i == 3, i >= 1});
      end
    end
    full_flag = 1'b1;
    idle(3);
    full_flag = 1'b0;
    vectors++;
    if (obs !== {1'b0, 8'h40, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow sticky {wr,data,done,ovf} got %h exp %h", obs, {1'b0, 8'h40, 1'b0, 1'b1});
    end
  endtask
  task automatic test_reset;
    logic [7:0] d [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) begin
      serial_data = 1'b1;
      data_ena = 1'b1;
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serial_data = i[0];
      @(posedge clk);
      #1;
    end
    vectors++;
    if (obs !== 11'h000) begin
      miscompares++;
      $display("FAIL reset midbyte obs got %h exp %h", obs, 11'h000);
    end
    reset_n = 1'b1;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i], 1'b0);
      vectors++;
      if (obs !== {1'b1, d[i], i == 3, 1'b0}) begin
        miscompares++;
        $display("FAIL reset byte%0d {wr,data,done,ovf} got %h exp %h", i, obs, {1'b1, d[i], i == 3, 1'b0});
      end
    end
    idle(2);
  endtask
  initial begin
    #1;
    test_reset_init;
    test_header_a;
    test_non_header;
    test_no_resync;
    test_partial;
    test_back_to_back;
    test_overflow;
    test_reset;
    vectors++;
    if (b2b !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_fifo_consecutive got %b exp 0", b2b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
